// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader feeding the instruction memory write port.
// Stream: LEN_HI, LEN_LO (N words), then N x (WORD_HI, WORD_LO), big-endian words.
// Optional feature macro LOADER_CHECKSUM_EN: a trailing XOR checksum byte is expected.
module imem_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              ready,
  output logic              busy,
  output logic              err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDatHi,
    StDatLo,
`ifdef LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StError
  } state_e;

  // State entered once the payload is complete (or N == 0).
`ifdef LOADER_CHECKSUM_EN
  localparam state_e StPost = StCsum;
`else
  localparam state_e StPost = StDone;
`endif

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [7:0]        hi_q;
  logic [15:0]       wdata_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       words_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic        xfer;
  logic        load_start;
  logic [15:0] len_full;

  assign xfer       = in_valid && in_ready;
  assign len_full   = {len_hi_q, in_data};
  assign load_start = start && (state_q == StIdle || state_q == StDone || state_q == StError);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: if (start) state_d = StLenHi;
      StLenHi: if (xfer) state_d = StLenLo;
      StLenLo: begin
        if (xfer) begin
          if (len_full == 16'd0)                     state_d = StPost;
          else if ({16'd0, len_full} > IMEM_DEPTH)   state_d = StError;
          else                                       state_d = StDatHi;
        end
      end
      StDatHi: if (xfer) state_d = StDatLo;
      StDatLo: begin
        if (xfer) state_d = (words_q + 16'd1 == len_q) ? StPost : StDatHi;
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: if (xfer) state_d = (in_data == csum_q) ? StDone : StError;
`endif
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Datapath: length/byte capture, registered write port, counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi_q <= '0;
      len_q    <= '0;
      hi_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      words_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      // Hold the address on the final word so the counter never wraps.
      if (we_q && words_q != len_q) addr_q <= addr_q + ADDR_W'(1);
      if (load_start) begin
        addr_q  <= '0;
        words_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q  <= '0;
`endif
      end
      if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
        csum_q <= csum_q ^ in_data;
`endif
        case (state_q)
          StLenHi: len_hi_q <= in_data;
          StLenLo: len_q    <= len_full;
          StDatHi: hi_q     <= in_data;
          StDatLo: begin
            wdata_q <= {hi_q, in_data};
            we_q    <= 1'b1;
            words_q <= words_q + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    case (state_q)
`ifdef LOADER_CHECKSUM_EN
      StCsum,
`endif
      StLenHi, StLenLo, StDatHi, StDatLo: busy = 1'b1;
      default: busy = 1'b0;
    endcase
    in_ready = busy;
    // ready waits out the final write so it rises the cycle after it.
    ready    = (state_q == StDone) && !we_q;
    err      = (state_q == StError);
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = words_q;

endmodule
